// File: rtl/adc_ltc2308_sequencer.sv
// adc_ltc2308_sequencer: round-robin LTC2308 channel scanner with pipeline-aware tagging and an output FIFO
module adc_ltc2308_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [7:0]                    ch_mask,
    output logic                          adc_start,
    output logic [3:0]                    adc_channel,
    input  logic                          adc_ready,
    input  logic [11:0]                   adc_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [11:0]                   sample_data,
    output logic [2:0]                    sample_channel,
    output logic [$clog2(FIFO_DEPTH):0]   sample_count,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, RUN, STOP_WAIT} state_t;

    state_t        state;
    logic [2:0]    cur, nxt, first;
    logic          pipe0_v, pipe1_v;
    logic [2:0]    pipe0_ch, pipe1_ch;
    logic [14:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          emit, push, pop, full;

    // next enabled channel strictly above 'from', wrapping; a lone bit returns itself
    function automatic logic [2:0] next_set(input logic [2:0] from, input logic [7:0] mask);
        logic [2:0] r;
        logic [2:0] idx;
        r = from;
        for (int i = 8; i >= 1; i--) begin
            idx = 3'(32'(from) + i);
            if (mask[idx]) r = idx;
        end
        return r;
    endfunction

    assign first        = next_set(3'd7, ch_mask);
    assign nxt          = next_set(cur, ch_mask);
    assign emit         = (state == RUN) && adc_ready && pipe1_v;
    assign full         = sample_count == FULL;
    assign pop          = sample_valid && sample_ready;
    assign push         = emit && (!full || pop);
    assign sample_valid = sample_count != '0;
    assign busy         = state != IDLE;
    assign sample_data    = mem[rd_ptr][11:0];
    assign sample_channel = mem[rd_ptr][14:12];

    // scan FSM: the config of frame k is read out in frame k+1, so tags ride a two-slot pipe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            adc_start   <= 1'b0;
            adc_channel <= 4'd0;
            cur         <= 3'd0;
            pipe0_v     <= 1'b0;
            pipe1_v     <= 1'b0;
            pipe0_ch    <= 3'd0;
            pipe1_ch    <= 3'd0;
        end else begin
            case (state)
                IDLE: if (enable && ch_mask != 8'd0) begin
                    state       <= RUN;
                    adc_start   <= 1'b1;
                    cur         <= first;
                    adc_channel <= {1'b0, first};
                    pipe0_v     <= 1'b1;
                    pipe0_ch    <= first;
                    pipe1_v     <= 1'b0;
                end
                RUN: if (adc_ready) begin
                    pipe1_v     <= pipe0_v;
                    pipe1_ch    <= pipe0_ch;
                    pipe0_v     <= 1'b1;
                    pipe0_ch    <= nxt;
                    cur         <= nxt;
                    adc_channel <= {1'b0, nxt};
                    if (!enable || ch_mask == 8'd0) state <= STOP_WAIT;
                end
                default: begin
                    state     <= IDLE;
                    adc_start <= 1'b0;
                    pipe0_v   <= 1'b0;
                    pipe1_v   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, fill level and sticky overflow (a drop beats a clear)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sample_count <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            sample_count <= sample_count + (AW+1)'(push) - (AW+1)'(pop);
            overflow     <= (emit && full && !pop) || (overflow && !overflow_clear);
        end
    end

    // FIFO storage; contents are meaningless while empty so no reset is needed
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {pipe1_ch, adc_data};
    end
endmodule

// File: tb/tb_adc_ltc2308_sequencer.sv
// tb_adc_ltc2308_sequencer: LTC2308 frame model plus FIFO/scan reference model against the sequencer
module tb_adc_ltc2308_sequencer;
    localparam int DEPTH = 4;
    localparam int FRAME = 80;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'd0;
    logic        adc_start;
    logic [3:0]  adc_channel;
    logic        adc_ready;
    logic [11:0] adc_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic [2:0]  sample_count;
    logic        overflow;
    logic        overflow_clear = 1'b0;
    logic        busy;

    logic rand_rdy = 1'b0, man_rdy = 1'b0, rnd_bit = 1'b0;
    int   total = 0, bad = 0;

    assign sample_ready = rand_rdy ? rnd_bit : man_rdy;

    adc_ltc2308_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
        .adc_start(adc_start), .adc_channel(adc_channel), .adc_ready(adc_ready), .adc_data(adc_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
        .sample_channel(sample_channel), .sample_count(sample_count), .overflow(overflow),
        .overflow_clear(overflow_clear), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference scan order: the enabled channels listed ascending, pick the first above 'from'
    function automatic logic [2:0] scan_next(input int from, input logic [7:0] m);
        int list[$];
        for (int c = 0; c < 8; c++) if (m[c]) list.push_back(c);
        if (list.size() == 0) return 3'(from);
        foreach (list[k]) if (list[k] > from) return 3'(list[k]);
        return 3'(list[0]);
    endfunction

    int          fcnt, ridx;
    logic [2:0]  cfg_cur, prev_cfg, data_ch, exp_ch;
    logic [11:0] cur_data, prev_data;
    logic        start_q, ovf_m;
    logic [7:0]  mask_q;
    logic [14:0] q[$];

    // ADC frame model (config captured early in a frame, result returned one frame later) and output model
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt <= 0; ridx <= 0; adc_ready <= 1'b0; adc_data <= 12'd0;
            cfg_cur <= 3'd0; prev_cfg <= 3'd0; data_ch <= 3'd0; exp_ch <= 3'd0;
            cur_data <= 12'd0; prev_data <= 12'd0; start_q <= 1'b0; mask_q <= 8'd0; ovf_m <= 1'b0;
            q.delete();
        end else begin
            logic pop_m, psh_m;
            pop_m = sample_ready && q.size() != 0;
            psh_m = adc_ready && ridx >= 1;
            start_q <= adc_start;
            mask_q  <= ch_mask;
            adc_ready <= 1'b0;
            if (adc_start && !start_q) begin
                ridx   <= 0;
                exp_ch <= scan_next(-1, mask_q);
            end
            if (adc_ready) begin
                ridx   <= ridx + 1;
                exp_ch <= scan_next(int'(exp_ch), ch_mask);
            end
            if (pop_m) void'(q.pop_front());
            if (psh_m && q.size() == DEPTH) ovf_m <= 1'b1;
            else begin
                if (psh_m) q.push_back({data_ch, adc_data});
                if (overflow_clear) ovf_m <= 1'b0;
            end
            if (!adc_start) fcnt <= 0;
            else if (fcnt == FRAME - 1) begin
                fcnt      <= 0;
                adc_ready <= 1'b1;
                adc_data  <= prev_data;
                data_ch   <= prev_cfg;
                prev_data <= cur_data;
                prev_cfg  <= cfg_cur;
            end else begin
                fcnt <= fcnt + 1;
                if (fcnt == 10) begin
                    cfg_cur  <= adc_channel[2:0];
                    cur_data <= 12'($urandom);
                end
            end
        end
    end

    // continuous comparison of the DUT outputs against the model, away from the active edge
    always @(negedge clock) begin
        rnd_bit <= 1'($urandom_range(0, 1));
        if (reset_n === 1'b1) begin
            check("valid", sample_valid, q.size() != 0);
            check("count", sample_count, q.size());
            check("overflow", overflow, ovf_m);
            if (q.size() != 0) begin
                check("head_ch", sample_channel, q[0][14:12]);
                check("head_data", sample_data, q[0][11:0]);
            end
            if (adc_start && fcnt == 11) check("adc_channel", adc_channel, {1'b0, exp_ch});
        end
    end

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clock);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (adc_ready !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clock);
            n++;
        end
        check("ready_timeout", adc_ready, 1);
    endtask

    task automatic check_reset(input string t);
        check({t, "_start"}, adc_start, 0);
        check({t, "_channel"}, adc_channel, 0);
        check({t, "_valid"}, sample_valid, 0);
        check({t, "_count"}, sample_count, 0);
        check({t, "_overflow"}, overflow, 0);
        check({t, "_busy"}, busy, 0);
    endtask

    initial begin
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset("rst");
        reset_n = 1'b1;
        // two-channel scan 0,2,0,2
        ch_mask = 8'h05; enable = 1'b1; rand_rdy = 1'b1;
        @(negedge clock);
        check("run_busy", busy, 1);
        check("run_start", adc_start, 1);
        check("run_first_ch", adc_channel, 0);
        frames(8);
        // single channel repeats 7
        ch_mask = 8'h80;
        frames(6);
        check("single_ch", adc_channel, 7);
        // stop mid-frame, then restart
        ch_mask = 8'h0F;
        frames(3);
        wait_ready();
        repeat (30) @(negedge clock);
        enable = 1'b0;
        wait_ready();
        @(negedge clock);
        check("stop_wait_start", adc_start, 1);
        check("stop_wait_busy", busy, 1);
        @(negedge clock);
        check("stopped_start", adc_start, 0);
        check("stopped_busy", busy, 0);
        repeat (20) @(negedge clock);
        check("idle_start", adc_start, 0);
        enable = 1'b1;
        @(negedge clock);
        check("restart_ch", adc_channel, 0);
        frames(4);
        // overflow with a stalled consumer
        rand_rdy = 1'b0; man_rdy = 1'b0;
        ch_mask = 8'($urandom_range(1, 255));
        frames(7);
        check("full_count", sample_count, 4);
        check("full_overflow", overflow, 1);
        wait_ready();
        @(negedge clock);
        overflow_clear = 1'b1;
        @(negedge clock);
        overflow_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
        wait_ready();
        man_rdy = 1'b1;
        @(negedge clock);
        man_rdy = 1'b0;
        check("pop_push_count", sample_count, 4);
        check("pop_push_ovf", overflow, 0);
        // mask switch 03 -> 30 on a ready edge
        man_rdy = 1'b1;
        ch_mask = 8'h03;
        frames(4);
        wait_ready();
        ch_mask = 8'h30;
        frames(5);
        // reset in the middle of a frame
        wait_ready();
        repeat (40) @(negedge clock);
        reset_n = 1'b0;
        #1 check_reset("midrst");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        frames(4);
        // randomized masks, enables, consumer and clears
        man_rdy = 1'b0; rand_rdy = 1'b1;
        for (int i = 0; i < 25; i++) begin
            ch_mask = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            enable = $urandom_range(0, 3) != 0;
            overflow_clear = $urandom_range(0, 4) == 0;
            repeat ($urandom_range(1, 200)) @(negedge clock);
        end
        overflow_clear = 1'b0;
        enable = 1'b0;
        frames(3);
        check("final_idle", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
